// File: rtl/addition_stage5_if.sv
// Handshake and data bundle for the FP add rounding stage.
// The slave view is the rounding block; the master view drives stage-4 data and downstream ready.
interface addition_stage5_if #(
  parameter int MENT_WIDTH = 23,
  parameter int EXPO_WIDTH = 8
);
  logic [MENT_WIDTH-1:0]            normalized_mentissa_in;
  logic [EXPO_WIDTH-1:0]            normalized_exponent_in;
  logic [2:0]                       grs_in;
  logic                             sign_in;
  logic [1:0]                       round_mode_in;
  logic                             valid_in;
  logic                             ready_out;
  logic                             ready_in;
  logic                             valid_out;
  logic [MENT_WIDTH+EXPO_WIDTH:0]   result_out;
  logic                             inexact_out;
  logic                             overflow_out;

  modport master (
    output normalized_mentissa_in, normalized_exponent_in, grs_in, sign_in,
           round_mode_in, valid_in, ready_in,
    input  ready_out, valid_out, result_out, inexact_out, overflow_out
  );

  modport slave (
    input  normalized_mentissa_in, normalized_exponent_in, grs_in, sign_in,
           round_mode_in, valid_in, ready_in,
    output ready_out, valid_out, result_out, inexact_out, overflow_out
  );
endinterface

// File: rtl/addition_stage5.sv
// Final rounding stage of the FP adder: two-stage pipeline that picks the rounding
// increment, applies it, and handles zero, inf/NaN passthrough and overflow to infinity.
module addition_stage5 #(
  parameter int MENT_WIDTH = 23,
  parameter int EXPO_WIDTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  addition_stage5_if.slave bus
);
  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_POS = 2'b10;

  logic                  advance;
  logic                  inc_d;
  logic                  any_grs;

  logic                  s1_valid;
  logic [MENT_WIDTH-1:0] s1_frac;
  logic [EXPO_WIDTH-1:0] s1_exp;
  logic                  s1_sign;
  logic                  s1_inc;
  logic                  s1_inexact;

  logic [MENT_WIDTH:0]   sum;
  logic [EXPO_WIDTH-1:0] exp_inc;
  logic [EXPO_WIDTH-1:0] r_exp;
  logic [MENT_WIDTH-1:0] r_frac;
  logic                  r_inexact;
  logic                  r_overflow;

  logic                          s2_valid;
  logic [MENT_WIDTH+EXPO_WIDTH:0] s2_result;
  logic                          s2_inexact;
  logic                          s2_overflow;

  // Both stages move together; a full S2 blocked downstream freezes the whole pipe.
  assign advance       = !s2_valid || bus.ready_in;
  assign bus.ready_out = advance;
  assign any_grs       = |bus.grs_in;

  always_comb begin
    inc_d = 1'b0;
    case (bus.round_mode_in)
      RM_RNE:  inc_d = bus.grs_in[2] && (|bus.grs_in[1:0] || bus.normalized_mentissa_in[0]);
      RM_RTZ:  inc_d = 1'b0;
      RM_POS:  inc_d = !bus.sign_in && any_grs;
      default: inc_d = bus.sign_in && any_grs;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_frac    <= '0;
      s1_exp     <= '0;
      s1_sign    <= 1'b0;
      s1_inc     <= 1'b0;
      s1_inexact <= 1'b0;
    end else if (advance) begin
      s1_valid   <= bus.valid_in;
      s1_frac    <= bus.normalized_mentissa_in;
      s1_exp     <= bus.normalized_exponent_in;
      s1_sign    <= bus.sign_in;
      s1_inc     <= inc_d;
      s1_inexact <= any_grs;
    end
  end

  assign sum     = {1'b0, s1_frac} + {{MENT_WIDTH{1'b0}}, s1_inc};
  assign exp_inc = s1_exp + {{(EXPO_WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    r_exp      = s1_exp;
    r_frac     = sum[MENT_WIDTH-1:0];
    r_inexact  = s1_inexact;
    r_overflow = 1'b0;
    if (s1_exp == '0) begin
      r_exp     = '0;
      r_frac    = '0;
      r_inexact = 1'b0;
    end else if (s1_exp == '1) begin
      r_frac    = s1_frac;
      r_inexact = 1'b0;
    end else if (sum[MENT_WIDTH]) begin
      // Mantissa carry-out: fraction wraps to zero and the exponent absorbs it.
      r_frac = '0;
      r_exp  = exp_inc;
      if (exp_inc == '1) r_overflow = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid    <= 1'b0;
      s2_result   <= '0;
      s2_inexact  <= 1'b0;
      s2_overflow <= 1'b0;
    end else if (advance) begin
      s2_valid    <= s1_valid;
      s2_result   <= {s1_sign, r_exp, r_frac};
      s2_inexact  <= r_inexact;
      s2_overflow <= r_overflow;
    end
  end

  assign bus.valid_out    = s2_valid;
  assign bus.result_out   = s2_result;
  assign bus.inexact_out  = s2_inexact;
  assign bus.overflow_out = s2_overflow;
endmodule

// File: tb/tb_addition_stage5.sv
// Self-checking bench for addition_stage5: directed rounding cases, stall, mid-stream reset,
// and randomized traffic scored against a queue-based arithmetic reference model.
module tb_addition_stage5;
  localparam int M = 23;
  localparam int E = 8;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  logic [33:0] exp_q[$];
  bit   rand_done;

  addition_stage5_if #(.MENT_WIDTH(M), .EXPO_WIDTH(E)) bus ();

  addition_stage5 #(.MENT_WIDTH(M), .EXPO_WIDTH(E)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Reference: {overflow, inexact, result[31:0]} from the rounding rules in plain integer math.
  function automatic logic [33:0] ref_round(input bit s, input int unsigned e, input int unsigned f,
                                            input bit [2:0] g, input bit [1:0] mode);
    bit          up;
    bit          any;
    int unsigned m;
    int unsigned ee;
    any = (g != 3'b000);
    if (e == 0) return {2'b00, s, 31'd0};
    if (e == 255) return {2'b00, s, e[7:0], f[22:0]};
    case (mode)
      2'd0:    up = g[2] && ((g[1:0] != 2'b00) || f[0]);
      2'd1:    up = 1'b0;
      2'd2:    up = !s && any;
      default: up = s && any;
    endcase
    m  = f + (up ? 1 : 0);
    ee = e;
    if (m == (1 << 23)) begin
      m  = 0;
      ee = ee + 1;
    end
    if (ee == 255) return {1'b1, any, s, 8'hFF, 23'd0};
    return {1'b0, any, s, ee[7:0], m[22:0]};
  endfunction

  // Scoreboard: handshakes are sampled on the falling edge, ahead of the rising edge that takes them.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.valid_out) begin
        check("sb_pending", {63'd0, exp_q.size() != 0}, 64'd1);
        if (exp_q.size() != 0) begin
          check("sb_result", {30'd0, bus.overflow_out, bus.inexact_out, bus.result_out}, {30'd0, exp_q[0]});
          if (bus.ready_in) void'(exp_q.pop_front());
        end
      end
      if (bus.valid_in && bus.ready_out)
        exp_q.push_back(ref_round(bus.sign_in, bus.normalized_exponent_in,
                                  bus.normalized_mentissa_in, bus.grs_in, bus.round_mode_in));
    end
  end

  task automatic send(input bit s, input logic [7:0] e, input logic [22:0] f,
                      input logic [2:0] g, input logic [1:0] mode);
    bus.sign_in                = s;
    bus.normalized_exponent_in = e;
    bus.normalized_mentissa_in = f;
    bus.grs_in                 = g;
    bus.round_mode_in          = mode;
    bus.valid_in               = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.ready_out) break;
    end
    if (!bus.ready_out) check("send_ready", {63'd0, bus.ready_out}, 64'd1);
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
  endtask

  task automatic run_one(input string tag, input bit s, input logic [7:0] e, input logic [22:0] f,
                         input logic [2:0] g, input logic [1:0] mode,
                         input logic [31:0] want_res, input bit want_inex, input bit want_ovf);
    int lat;
    lat = 0;
    send(s, e, f, g, mode);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus.valid_out) begin
        lat = i;
        break;
      end
    end
    check({tag, "_latency"}, lat, 2);
    check(tag, {30'd0, bus.overflow_out, bus.inexact_out, bus.result_out},
          {30'd0, want_ovf, want_inex, want_res});
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
    check(tag, exp_q.size(), 0);
    #1;
  endtask

  initial begin
    errors                     = 0;
    checks                     = 0;
    rand_done                  = 1'b0;
    rst_n                      = 1'b0;
    bus.valid_in               = 1'b0;
    bus.ready_in               = 1'b1;
    bus.sign_in                = 1'b0;
    bus.normalized_exponent_in = '0;
    bus.normalized_mentissa_in = '0;
    bus.grs_in                 = '0;
    bus.round_mode_in          = '0;

    #1;
    check("rst_valid_out", {63'd0, bus.valid_out}, 64'd0);
    check("rst_result", {32'd0, bus.result_out}, 64'd0);
    check("rst_flags", {62'd0, bus.inexact_out, bus.overflow_out}, 64'd0);
    check("rst_ready_out", {63'd0, bus.ready_out}, 64'd1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    check("post_rst_ready", {63'd0, bus.ready_out}, 64'd1);
    @(posedge clk);
    #1;

    run_one("rne_tie_odd",  0, 8'h80, 23'h000001, 3'b100, 2'b00, 32'h40000002, 1, 0);
    run_one("rne_tie_even", 0, 8'h80, 23'h000002, 3'b100, 2'b00, 32'h40000002, 1, 0);
    run_one("rne_carry",    0, 8'h7F, 23'h7FFFFF, 3'b110, 2'b00, 32'h40000000, 1, 0);
    run_one("rne_overflow", 0, 8'hFE, 23'h7FFFFF, 3'b111, 2'b00, 32'h7F800000, 1, 1);
    run_one("rtz",          1, 8'h80, 23'h000010, 3'b011, 2'b01, 32'hC0000010, 1, 0);
    run_one("rpos_neg",     1, 8'h80, 23'h000010, 3'b011, 2'b10, 32'hC0000010, 1, 0);
    run_one("rneg_neg",     1, 8'h80, 23'h000010, 3'b011, 2'b11, 32'hC0000011, 1, 0);
    run_one("zero_exp",     1, 8'h00, 23'h000123, 3'b111, 2'b11, 32'h80000000, 0, 0);
    run_one("inf_nan_pass", 0, 8'hFF, 23'h400001, 3'b111, 2'b10, 32'h7FC00001, 0, 0);

    // Three back-to-back inputs against a stalled downstream.
    bus.ready_in = 1'b0;
    fork
      begin
        send(0, 8'h81, 23'h000100, 3'b100, 2'b00);
        send(1, 8'h82, 23'h7FFFFF, 3'b101, 2'b11);
        send(0, 8'h83, 23'h0ABCDE, 3'b010, 2'b10);
      end
      begin
        repeat (2) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check("stall_valid_out", {63'd0, bus.valid_out}, 64'd1);
          check("stall_ready_out", {63'd0, bus.ready_out}, 64'd0);
        end
        @(posedge clk);
        #1 bus.ready_in = 1'b1;
      end
    join
    drain("stall_drain");

    // Reset with both stages holding data.
    bus.ready_in = 1'b0;
    send(0, 8'h90, 23'h000001, 3'b111, 2'b00);
    send(1, 8'h91, 23'h000002, 3'b111, 2'b00);
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_valid_out", {63'd0, bus.valid_out}, 64'd0);
    check("midrst_result", {32'd0, bus.result_out}, 64'd0);
    check("midrst_ready_out", {63'd0, bus.ready_out}, 64'd1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    bus.ready_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_stale", {63'd0, bus.valid_out}, 64'd0);
    end
    @(posedge clk);
    #1;
    run_one("post_midrst", 0, 8'h80, 23'h000001, 3'b100, 2'b00, 32'h40000002, 1, 0);

    // Randomized traffic with random downstream backpressure.
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          int unsigned r;
          logic [7:0]  e;
          logic [22:0] f;
          r = $urandom_range(0, 9);
          if (r == 0)      e = 8'h00;
          else if (r == 1) e = 8'hFF;
          else if (r == 2) e = 8'hFE;
          else             e = 8'($urandom_range(1, 254));
          f = ($urandom_range(0, 3) == 0) ? 23'h7FFFFF : 23'($urandom);
          send(1'($urandom), e, f, 3'($urandom), 2'($urandom));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 bus.ready_in = ($urandom_range(0, 3) != 0);
        end
        bus.ready_in = 1'b1;
      end
    join
    drain("random_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/addition_stage5.md
ADDITION_STAGE5 -- requirements
Module: addition_stage5

Interface
REQ-001 SHALL have parameter MENT_WIDTH, default 23, mantissa fraction width.
REQ-002 SHALL have parameter EXPO_WIDTH, default 8, exponent width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 SHALL have port normalized_mentissa_in  input  MENT_WIDTH  normalized fraction from stage 4.
REQ-006 SHALL have port normalized_exponent_in  input  EXPO_WIDTH  normalized exponent from stage 4.
REQ-007 SHALL have port grs_in  input  3  guard/round/sticky bits, guard is bit 2.
REQ-008 SHALL have port sign_in  input  1  result sign.
REQ-009 SHALL have port round_mode_in  input  2  00 RNE, 01 RTZ, 10 toward +inf, 11 toward -inf.
REQ-010 SHALL have port valid_in  input  1  upstream data valid.
REQ-011 SHALL have port ready_out  output  1  block accepts input this cycle.
REQ-012 SHALL have port ready_in  input  1  downstream accepts output.
REQ-013 SHALL have port valid_out  output  1  result valid.
REQ-014 SHALL have port result_out  output  1+EXPO_WIDTH+MENT_WIDTH  packed {sign, exponent, fraction}.
REQ-015 SHALL have port inexact_out  output  1  high when grs_in of the result was nonzero.
REQ-016 SHALL have port overflow_out  output  1  high when rounding carried exponent to all-ones.

Function
REQ-017 SHALL be a two-stage pipeline: S1 registers inputs plus increment decision, S2 registers the rounded result; latency 2 cycles from accepted input to valid_out.
REQ-018 SHALL define advance = !S2_valid || ready_in; ready_out = advance; both stages load only when advance is high.
REQ-019 SHALL accept a transfer when valid_in && ready_out; S1_valid loads valid_in on advance (bubbles propagate).
REQ-020 SHALL hold result_out, valid_out, inexact_out, overflow_out stable while valid_out && !ready_in.
REQ-021 SHALL compute increment in S1: RNE = G && (R || S || frac LSB); RTZ = 0; +inf = !sign && (G|R|S); -inf = sign && (G|R|S).
REQ-022 SHALL compute in S2 fraction+increment at MENT_WIDTH+1 bits; on carry-out the fraction becomes 0 and the exponent increments by 1.
REQ-023 SHALL set overflow_out=1 and output exponent all-ones, fraction 0 (infinity, sign kept) when the incremented exponent equals all-ones.
REQ-024 SHALL treat input exponent 0 as zero: output exponent 0, fraction 0, sign kept, inexact_out=0, no rounding.
REQ-025 SHALL pass input exponent all-ones (inf/NaN) unrounded with inexact_out=0, overflow_out=0.
REQ-026 SHALL set inexact_out = |grs_in for all other inputs, independent of round mode.
REQ-027 SHALL sustain one result per cycle while ready_in is held high.

Reset
REQ-028 SHALL, on rst_n low, immediately clear S1_valid, S2_valid, valid_out, result_out, inexact_out, overflow_out to 0, regardless of clock.
REQ-029 SHALL discard in-flight data on reset mid-operation; first valid_out after release only from inputs accepted after release.
REQ-030 SHALL drive ready_out=1 during and right after reset (pipeline empty).

Verification
REQ-031 SHALL pass: RNE, exp 0x80, frac 0x000001, grs 100 -> frac 0x000002, inexact 1; frac 0x000002, grs 100 -> frac 0x000002.
REQ-032 SHALL pass: RNE, exp 0x7F, frac 0x7FFFFF, grs 110 -> exp 0x80, frac 0x000000, overflow 0, two cycles later.
REQ-033 SHALL pass: RNE, sign 0, exp 0xFE, frac 0x7FFFFF, grs 111 -> result 0x7F800000, overflow 1.
REQ-034 SHALL pass: frac 0x000010, grs 011, sign 1: RTZ -> 0x000010; +inf -> 0x000010; -inf -> 0x000011; all inexact 1.
REQ-035 SHALL pass: three back-to-back inputs, ready_in low 4 cycles -> ready_out drops once S2 full, valid_out held with first result stable, all three delivered in order, none lost or duplicated.
REQ-036 SHALL pass: rst_n pulsed low mid-stream with both stages full -> valid_out 0 asynchronously, no stale result after release.
